// File: rtl/pattern_match_counter.sv
// pattern_match_counter
//   Serial bit-stream pattern counter. Each accepted bit, together with the
//   preceding PAT_W-1 accepted bits, is compared against a runtime-loadable
//   pattern. A same-cycle (Mealy) match pulse is produced and a running count
//   of matches is kept, with overlapping or non-overlapping counting chosen
//   per match by the overlap input.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   CNT_W    match counter width (1..16)
//   PAT_INIT pattern held after reset; MSB is the bit that must arrive first
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   in        in   serial data bit
//   in_valid  in   qualifies in; unqualified cycles hold all state
//   overlap   in   1 = overlapping matches, 0 = non-overlapping
//   pat       in   new pattern value
//   pat_load  in   loads pat and clears history, count and overflow
//   match     out  combinational: the current accepted bit completes the pattern
//   count     out  matches since reset or pat_load
//   overflow  out  sticky: a match occurred with count at all-ones
//
// Configuration
//   PATTERN_MATCH_COUNTER_SATURATE_EN defined   : count holds at all-ones
//   PATTERN_MATCH_COUNTER_SATURATE_EN undefined : count wraps to zero
module pattern_match_counter #(
    parameter int unsigned      PAT_W    = 4,
    parameter int unsigned      CNT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pat,
    input  logic             pat_load,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned      HIST_W    = PAT_W - 1;
    localparam int unsigned      FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_reg;
    logic [HIST_W-1:0] hist;
    logic [FILL_W-1:0] fill;
    logic              accept;
    logic              full;

    // A bit is consumed only when qualified and not overridden by a load
    assign accept = in_valid & ~pat_load;
    assign full   = (fill == FILL_FULL);
    assign match  = accept & full & ({hist, in} == pat_reg);

    // Pattern, history, fill level, count and overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg  <= PAT_INIT;
            hist     <= '0;
            fill     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (pat_load) begin
            pat_reg  <= pat;
            hist     <= '0;
            fill     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Newest bit enters at the LSB; the oldest falls off the top
            hist <= HIST_W'({hist, in});

            // Non-overlap mode restarts collection after a match
            if (match && !overlap) begin
                fill <= '0;
            end else if (!full) begin
                fill <= fill + FILL_W'(1);
            end

            if (match) begin
                if (count == CNT_MAX) begin
                    overflow <= 1'b1;
`ifdef PATTERN_MATCH_COUNTER_SATURATE_EN
                    count    <= CNT_MAX;
`else
                    count    <= '0;
`endif
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule
